// File: rtl/char_buffer_16x16_pkg.sv
// Shared types and character constants for the 16x16 character buffer.
package char_buffer_16x16_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;
    localparam int         GRID_DIM  = 16;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/char_ram_256x7.sv
// 256 x 7 character store: one write port, one registered read port, read-first.
// Only the read register is reset; the array itself carries no reset so it can
// map onto RAM primitives.
module char_ram_256x7 #(
    parameter logic [6:0] RESET_DATA = 7'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [6:0] wdata,
    input  logic [7:0] raddr,
    output logic [6:0] rdata
);

    logic [6:0] mem [256];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; non-blocking update of mem gives old data on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= RESET_DATA;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/char_buffer_16x16.sv
// 16x16 character buffer fed by an ASCII byte stream, with cursor handling
// (CR, LF, BS, wrap) and a 256-cycle clear sweep.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepting bytes, cursor moves and writes happen here
// ST_CLEAR | sweeping FILL_CHAR over every address, one per cycle
module char_buffer_16x16
    import char_buffer_16x16_pkg::*;
#(
    parameter logic [6:0] FILL_CHAR = 7'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       clear,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic [7:0] cursor_xy,
    output logic       busy
);

    state_t     state, state_nx;
    logic [7:0] sweep, sweep_nx;
    logic [7:0] cursor, cursor_nx;
    logic       we;
    logic [7:0] waddr;
    logic [6:0] wdata;
    logic       accept;

    assign rx_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_CLEAR);
    assign accept    = rx_valid && rx_ready;
    assign cursor_xy = cursor;

    // State, sweep counter and cursor registers; reset lands in a fresh sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_CLEAR;
            sweep  <= 8'h00;
            cursor <= 8'h00;
        end else begin
            state  <= state_nx;
            sweep  <= sweep_nx;
            cursor <= cursor_nx;
        end
    end

    // Next-state, cursor movement and write-port control.
    always_comb begin
        state_nx  = state;
        sweep_nx  = sweep;
        cursor_nx = cursor;
        we        = 1'b0;
        waddr     = cursor;
        wdata     = rx_data[6:0];
        case (state)
            ST_CLEAR: begin
                we       = 1'b1;
                waddr    = sweep;
                wdata    = FILL_CHAR;
                sweep_nx = sweep + 8'h01;
                if (sweep == 8'hFF) begin
                    state_nx  = ST_IDLE;
                    cursor_nx = 8'h00;
                end
            end
            default: begin
                if (clear) begin
                    // A byte accepted alongside clear is swallowed.
                    state_nx = ST_CLEAR;
                    sweep_nx = 8'h00;
                end else if (accept) begin
                    if (is_printable(rx_data)) begin
                        we        = 1'b1;
                        cursor_nx = cursor + 8'h01;
                    end else if (rx_data == CH_CR) begin
                        cursor_nx = {cursor[7:4], 4'h0};
                    end else if (rx_data == CH_LF) begin
                        cursor_nx = {cursor[7:4] + 4'h1, 4'h0};
                    end else if (rx_data == CH_BS) begin
                        // Backspace stops at column 0 rather than climbing rows.
                        if (cursor[3:0] != 4'h0) begin
                            cursor_nx = cursor - 8'h01;
                            we        = 1'b1;
                            waddr     = cursor - 8'h01;
                            wdata     = FILL_CHAR;
                        end
                    end
                end
            end
        endcase
    end

    char_ram_256x7 #(
        .RESET_DATA (FILL_CHAR)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (char_xy),
        .rdata (char_code)
    );

endmodule

// File: tb/tb_char_buffer_16x16.sv
// Directed bench for char_buffer_16x16; read results go through a scoreboard.
module tb_char_buffer_16x16;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       clear;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic [7:0] cursor_xy;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic  rd_req   = 1'b0;
    logic  rd_req_d = 1'b0;
    int    exp_q [$];
    string name_q[$];

    char_buffer_16x16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .clear     (clear),
        .char_xy   (char_xy),
        .char_code (char_code),
        .cursor_xy (cursor_xy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read requests surface on char_code one edge later.
    always @(posedge clk) rd_req_d <= rd_req;

    // Monitor: pop and compare whenever a read result is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req_d) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected got=%h required=none", char_code);
                end else begin
                    int    e;
                    string n;
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (int'(char_code) != e) begin
                        bad++;
                        $display("FAIL %s got=%h required=%h", n, char_code, e[6:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic rd(input logic [7:0] a, input int exp, input string nm);
        char_xy = a;
        rd_req  = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Counts negedges with busy high, starting from 'start', and checks for 256.
    task automatic wait_clear(input int start, input string nm);
        int n;
        int rdy_bad;
        n       = start;
        rdy_bad = 0;
        while (busy && n < 1000) begin
            if (rx_ready) rdy_bad++;
            n++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check({nm, "_len"}, n, 256);
        check({nm, "_ready_low"}, rdy_bad, 0);
        check({nm, "_cursor"}, int'(cursor_xy), 8'h00);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        clear    = 1'b0;
        char_xy  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_busy", int'(busy), 1);
        check("rst_ready", int'(rx_ready), 0);
        check("rst_cursor", int'(cursor_xy), 8'h00);
        check("rst_char", int'(char_code), 8'h20);

        // Release with a byte already offered; it must not be taken during the sweep.
        rx_data  = 8'h58;
        rx_valid = 1'b1;
        rst_n    = 1'b1;
        wait_clear(0, "init_clr");
        for (int a = 0; a < 256; a++) rd(8'(a), 8'h20, "init_blank");

        // "Hi" LF "A"
        send_str("Hi");
        send(8'h0A);
        send("A");
        check("hi_cursor", int'(cursor_xy), 8'h11);
        rd(8'h00, 8'h48, "hi_00");
        rd(8'h01, 8'h69, "hi_01");
        rd(8'h10, 8'h41, "hi_10");

        // Discarded codes, then CR.
        send(8'h07);
        send(8'h7F);
        send(8'hC1);
        check("discard_cursor", int'(cursor_xy), 8'h11);
        rd(8'h11, 8'h20, "discard_nowrite");
        send("B");
        send(8'h0D);
        check("cr_cursor", int'(cursor_xy), 8'h10);
        rd(8'h11, 8'h42, "cr_prev_char");

        // Walk to 0xFF and wrap.
        repeat (14) send(8'h0A);
        check("lf_row15", int'(cursor_xy), 8'hF0);
        send_str("ABCDEFGHIJKLMNO");
        check("at_ff", int'(cursor_xy), 8'hFF);
        send("Z");
        check("wrap_cursor", int'(cursor_xy), 8'h00);
        rd(8'hFF, 8'h5A, "wrap_ff");
        rd(8'hFE, 8'h4F, "wrap_fe");
        repeat (15) send(8'h0A);
        send_str("xyz");
        check("at_f3", int'(cursor_xy), 8'hF3);
        send(8'h0A);
        check("lf_wrap", int'(cursor_xy), 8'h00);
        rd(8'hF2, 8'h7A, "xyz_f2");

        // Backspace.
        send_str("ab");
        rd(8'h01, 8'h62, "bs_pre_01");
        send(8'h08);
        check("bs1_cursor", int'(cursor_xy), 8'h01);
        send(8'h08);
        send(8'h08);
        check("bs3_cursor", int'(cursor_xy), 8'h00);
        rd(8'h00, 8'h20, "bs_00");
        rd(8'h01, 8'h20, "bs_01");
        send(8'h0A);
        send(8'h08);
        check("bs_col0_cursor", int'(cursor_xy), 8'h10);
        rd(8'h10, 8'h41, "bs_col0_10");
        rd(8'h0F, 8'h20, "bs_col0_0f");

        // Read-first collision.
        rx_data  = "R";
        rx_valid = 1'b1;
        char_xy  = 8'h10;
        rd_req   = 1'b1;
        exp_q.push_back(8'h41);
        name_q.push_back("rdfirst_old");
        @(negedge clk);
        rx_valid = 1'b0;
        rd_req   = 1'b0;
        rd(8'h10, 8'h52, "rdfirst_new");
        check("rdfirst_cursor", int'(cursor_xy), 8'h11);

        // Clear colliding with 'Q' at 0x05.
        repeat (15) send(8'h0A);
        send_str("01234");
        check("q_cursor_pre", int'(cursor_xy), 8'h05);
        check("q_ready", int'(rx_ready), 1);
        clear    = 1'b1;
        rx_data  = "Q";
        rx_valid = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        rx_valid = 1'b0;
        check("q_busy_rise", int'(busy), 1);
        check("q_cursor_held", int'(cursor_xy), 8'h05);
        rd(8'h05, 8'h20, "q_not_written");
        rd(8'h02, 8'h32, "q_clear_pending");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_clear(3, "q_clr");
        for (int a = 0; a < 6; a++) rd(8'(a), 8'h20, "q_blank");

        // Reset in the middle of a sweep at address 0x80.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (128) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 1);
        check("midrst_ready", int'(rx_ready), 0);
        check("midrst_char", int'(char_code), 8'h20);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_clear(0, "midrst_clr");
        send("K");
        check("post_cursor", int'(cursor_xy), 8'h01);
        rd(8'h00, 8'h4B, "post_00");

        @(negedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/char_buffer_16x16.md
CHAR_BUFFER_16X16 -- requirements
Module: char_buffer_16x16

Interface
REQ-001 Parameter FILL_CHAR, default 7'h20, is the character code written on clear and by backspace.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 rx_data  input  8  is the incoming ASCII byte.
REQ-005 rx_valid  input  1  means rx_data holds a valid byte.
REQ-006 rx_ready  output  1  means the block can accept a byte this cycle.
REQ-007 clear  input  1  is a single-cycle request to blank the whole buffer.
REQ-008 char_xy  input  8  is the read address: row in [7:4], column in [3:0].
REQ-009 char_code  output  7  is the registered character at char_xy.
REQ-010 cursor_xy  output  8  is the next write position: row in [7:4], column in [3:0].
REQ-011 busy  output  1  is high while the clear sweep runs.

Function
REQ-012 Storage SHALL be 256 x 7-bit, addressed {row,col}, with one write port and one synchronous read port.
REQ-013 FSM states SHALL be IDLE and CLEAR.
REQ-014 rx_ready SHALL equal (state==IDLE).
REQ-015 busy SHALL equal (state==CLEAR).
REQ-016 A byte SHALL be accepted only in a cycle with rx_valid && rx_ready, and at most one byte per cycle.
REQ-017 Accepted 0x20..0x7E: write rx_data[6:0] at cursor_xy, then cursor_xy+1 (8-bit wrap, 0xFF->0x00, so row 15 col 15 wraps to 0,0).
REQ-018 Accepted 0x0D (CR): column->0; row unchanged; no write.
REQ-019 Accepted 0x0A (LF): row->row+1 mod 16; column->0; no write.
REQ-020 Accepted 0x08 (BS), column>0: cursor_xy-1, then FILL_CHAR written at the new cursor in the same cycle.
REQ-021 Accepted 0x08 (BS), column==0: no action (no wrap to the previous row).
REQ-022 Any other accepted byte (other control codes, 0x7F, bit7=1) SHALL be consumed and discarded with no write and no cursor change.
REQ-023 clear in IDLE SHALL enter CLEAR on the next edge.
REQ-024 If clear and an accepted byte coincide, clear SHALL win; the byte is consumed but not written and the cursor does not change.
REQ-025 clear asserted while in CLEAR SHALL be ignored.
REQ-026 CLEAR SHALL write FILL_CHAR to addresses 0x00..0xFF using an 8-bit sweep counter, one address per cycle.
REQ-027 CLEAR SHALL last exactly 256 cycles, then set cursor_xy=0x00 and return to IDLE.
REQ-028 char_code SHALL update one clock after char_xy is sampled (1-cycle latency) in every state.
REQ-029 A read and a write to the same address in the same cycle SHALL return the old data (read-first).

Reset
REQ-030 While rst_n=0: state=CLEAR, sweep counter=0, cursor_xy=0x00, char_code=FILL_CHAR, rx_ready=0, busy=1.
REQ-031 After reset is released, the block SHALL perform a full 256-cycle clear before first asserting rx_ready.
REQ-032 Reset asserted mid-operation (mid-sweep or mid-write) SHALL abort immediately and restart the sweep from address 0x00.
REQ-033 Storage contents SHALL NOT be reset directly, so the array can map to block or distributed RAM.

Structure
REQ-034 The shared package SHALL hold: the state enum, the control codes CR=0x0D, LF=0x0A and BS=0x08, printable bounds 0x20/0x7E, and GRID_DIM=16.
REQ-035 The storage array SHALL be one sub-module, char_ram_256x7: 1 write port, 1 registered read port, read-first.

Verification
REQ-036 Release reset, hold rx_valid=1 -> busy=1 and rx_ready=0 for exactly 256 cycles; then every address reads 0x20 and cursor_xy=0x00.
REQ-037 Send "Hi" then LF then "A" -> addr 0x00=0x48, 0x01=0x69, 0x10=0x41; cursor_xy=0x11.
REQ-038 From cursor 0xFF, send 'Z' -> addr 0xFF=0x5A and cursor_xy=0x00; then LF from 0xF3 -> cursor_xy=0x00.
REQ-039 Send "ab" then BS twice then BS again -> addr 0x00 and 0x01 = 0x20, cursor_xy=0x00; the third BS causes no change.
REQ-040 Pulse clear in the same cycle as an accepted 'Q' at cursor 0x05 -> 'Q' not written, busy rises next cycle, and after 256 cycles cursor_xy=0x00.
REQ-041 Drop rst_n at sweep address 0x80 for 3 cycles -> after release, the sweep restarts at 0x00 and busy stays high for a full 256 cycles.
